// File: rtl/aemb_wbmem_pkg.sv
// aemb_wbmem_pkg: shared types and constants for the dual-port Wishbone memory
package aemb_wbmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
`ifdef AEMB_WBMEM_STALL_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
endpackage

// File: rtl/aemb_wbmem_port.sv
// aemb_wbmem_port: per-port handshake FSM with wait counter, registered ack and capture strobe
module aemb_wbmem_port
  import aemb_wbmem_pkg::*;
(
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          req,
  input  logic          abort,
  input  logic [CW-1:0] wait_n,
  output logic          ack,
  output logic          cap
);
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // state and wait counter registers
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end
  // next state; cap marks the edge entering ACK, where data is captured and writes commit
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    cap = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        cap = wait_n == '0;
        nxt = cap ? ACK : WAIT;
        cnt_nxt = wait_n;
      end
      WAIT: if (abort) begin
        nxt = IDLE;
        cnt_nxt = '0;
      end else if (cnt == CW'(1)) begin
        nxt = ACK;
        cap = 1'b1;
        cnt_nxt = '0;
      end else cnt_nxt = cnt - CW'(1);
      ACK: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign ack = state == ACK;
endmodule

// File: rtl/aemb_wbmem.sv
// aemb_wbmem: dual-port Wishbone memory (iwb read-only, dwb read/write); AEMB_WBMEM_STALL_EN adds LFSR random stalls
module aemb_wbmem
  import aemb_wbmem_pkg::*;
#(
  parameter int          AW        = 16,
  parameter int          IWAIT     = 0,
  parameter int          DWAIT     = 0,
  parameter string       INIT_FILE = "dump.vmem",
  parameter logic [15:0] SEED      = DEF_SEED
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-3:0] iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic          dwb_cyc_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-3:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o
);
  localparam int DEPTH = 2 ** (AW - 2);
  logic [31:0] mem [DEPTH];
  logic [CW-1:0] iwait_n, dwait_n;
  logic icap, dcap, dreq;
  assign dreq = dwb_cyc_i & dwb_stb_i;
`ifdef AEMB_WBMEM_STALL_EN
  logic [15:0] lfsr;
  // free-running Fibonacci LFSR supplying 0..3 extra wait cycles per port
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) lfsr <= SEED;
    else lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
  assign iwait_n = CW'(IWAIT) + CW'(lfsr[1:0]);
  assign dwait_n = CW'(DWAIT) + CW'(lfsr[3:2]);
`else
  assign iwait_n = CW'(IWAIT);
  assign dwait_n = CW'(DWAIT);
`endif
  aemb_wbmem_port u_iwb (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .req(iwb_stb_i), .abort(!iwb_stb_i),
    .wait_n(iwait_n), .ack(iwb_ack_o), .cap(icap)
  );
  aemb_wbmem_port u_dwb (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .req(dreq), .abort(!dreq),
    .wait_n(dwait_n), .ack(dwb_ack_o), .cap(dcap)
  );
  // read data registered on ACK entry; a same-edge dwb write is not yet visible
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      iwb_dat_o <= '0;
      dwb_dat_o <= '0;
    end else begin
      if (icap) iwb_dat_o <= mem[iwb_adr_i];
      if (dcap) dwb_dat_o <= mem[dwb_adr_i];
    end
  end
  // byte-lane write commit on dwb ACK entry; array is never reset
  always_ff @(posedge sys_clk_i) begin
    if (dcap && dwb_wre_i)
      for (int b = 0; b < 4; b++)
        if (dwb_sel_i[b]) mem[dwb_adr_i][8*b +: 8] <= dwb_dat_i[8*b +: 8];
  end
endmodule
